// File: rtl/vga_sync_if.sv
// Pixel-side signal bundle of the VGA timing generator: renderer colour in,
// sync/active/coordinate and gated colour out.
interface vga_sync_if #(
  parameter int RGB_W = 12,
  parameter int CNT_W = 10
);
  logic [RGB_W-1:0] rgb_in;
  logic [RGB_W-1:0] rgb_out;
  logic             vidstate;
  logic             hsync;
  logic             vsync;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;

  modport master (
    input  rgb_in,
    output rgb_out, vidstate, hsync, vsync, h, v
  );

  modport slave (
    output rgb_in,
    input  rgb_out, vidstate, hsync, vsync, h, v
  );
endinterface

// File: rtl/vga_sync.sv
// VGA 640x480@60 timing generator: free-running h/v counters, registered
// sync and active-video flags, and combinational blanking of the pixel colour.
module vga_sync #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int RGB_W     = 12,
  parameter int CNT_W     = 10
) (
  input  logic       clk,
  input  logic       rst,
  vga_sync_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, v_q;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             hsync_q, vsync_q, vid_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    h_nxt = h_q + CNT_W'(1);
    v_nxt = v_q;
    if (h_q == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end
  end

  // Decoding from the next-state counts keeps sync/active aligned with h/v.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      vid_q   <= 1'b0;
    end else begin
      h_q     <= h_nxt;
      v_q     <= v_nxt;
      hsync_q <= (h_nxt >= HS_START && h_nxt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= (v_nxt >= VS_START && v_nxt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      vid_q   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end
  end

  assign vif.h        = h_q;
  assign vif.v        = v_q;
  assign vif.hsync    = hsync_q;
  assign vif.vsync    = vsync_q;
  assign vif.vidstate = vid_q;
  assign vif.rgb_out  = vid_q ? vif.rgb_in : '0;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full-size timing plus a shrunken instance
// that exercises whole frames, sync pulses and wraps in a few hundred clocks.
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #20 clk = ~clk;

  vga_sync_if #(.RGB_W(12), .CNT_W(10)) vif_a ();
  vga_sync_if #(.RGB_W(12), .CNT_W(10)) vif_b ();

  vga_sync u_big (
    .clk (clk),
    .rst (rst),
    .vif (vif_a)
  );

  vga_sync #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .vif (vif_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_rgb(input logic [11:0] val);
    vif_a.rgb_in = val;
    vif_b.rgb_in = val;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_h"},   32'(vif_a.h), 799);
    check({tag, "_a_v"},   32'(vif_a.v), 524);
    check({tag, "_a_hs"},  32'(vif_a.hsync), 1);
    check({tag, "_a_vs"},  32'(vif_a.vsync), 1);
    check({tag, "_a_vid"}, 32'(vif_a.vidstate), 0);
    check({tag, "_a_rgb"}, 32'(vif_a.rgb_out), 0);
    check({tag, "_b_h"},   32'(vif_b.h), 13);
    check({tag, "_b_v"},   32'(vif_b.v), 6);
    check({tag, "_b_rgb"}, 32'(vif_b.rgb_out), 0);
  endtask

  task automatic check_origin(input string tag);
    check({tag, "_a_h"},   32'(vif_a.h), 0);
    check({tag, "_a_v"},   32'(vif_a.v), 0);
    check({tag, "_a_vid"}, 32'(vif_a.vidstate), 1);
    check({tag, "_a_rgb"}, 32'(vif_a.rgb_out), 32'hFFF);
    check({tag, "_b_h"},   32'(vif_b.h), 0);
    check({tag, "_b_v"},   32'(vif_b.v), 0);
    check({tag, "_b_rgb"}, 32'(vif_b.rgb_out), 32'hFFF);
  endtask

  initial begin
    int hs_low_cnt;
    int last_fall;
    logic prev_vs;

    set_rgb(12'hFFF);
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("rst");

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_origin("first");

    hs_low_cnt = 0;
    last_fall  = -1;
    prev_vs    = vif_b.vsync;

    // n counts clocks since the (0,0) edge; expectations are derived from n alone.
    for (int n = 1; n < 17100; n++) begin
      int eh, ev, sh, sv;
      logic [11:0] rgb;
      logic evid, svid;
      @(negedge clk);
      rgb = 12'(n);
      set_rgb(rgb);
      #1;
      eh   = n % 800;
      ev   = n / 800;
      evid = (eh < 640) && (ev < 480);
      check("a_h",   32'(vif_a.h), 32'(eh));
      check("a_v",   32'(vif_a.v), 32'(ev));
      check("a_vid", 32'(vif_a.vidstate), 32'(evid));
      check("a_hs",  32'(vif_a.hsync), (eh >= 656 && eh <= 751) ? 0 : 1);
      check("a_vs",  32'(vif_a.vsync), 1);
      check("a_rgb", 32'(vif_a.rgb_out), evid ? 32'(rgb) : 0);
      if (n < 800 && vif_a.hsync == 1'b0) hs_low_cnt++;

      sh   = n % 14;
      sv   = (n / 14) % 7;
      svid = (sh < 8) && (sv < 4);
      check("b_h",   32'(vif_b.h), 32'(sh));
      check("b_v",   32'(vif_b.v), 32'(sv));
      check("b_vid", 32'(vif_b.vidstate), 32'(svid));
      check("b_hs",  32'(vif_b.hsync), (sh >= 10 && sh <= 12) ? 0 : 1);
      check("b_vs",  32'(vif_b.vsync), (sv == 5) ? 0 : 1);
      check("b_rgb", 32'(vif_b.rgb_out), svid ? 32'(rgb) : 0);
      if (prev_vs && !vif_b.vsync) begin
        if (last_fall >= 0) check("b_vs_period", 32'(n - last_fall), 98);
        last_fall = n;
      end
      prev_vs = vif_b.vsync;
    end
    check("a_hs_low_count", 32'(hs_low_cnt), 96);

    // Mid-frame reset: lands at (300,21) on the big instance, no clock edge needed.
    @(posedge clk);
    #2;
    set_rgb(12'hFFF);
    check("mid_a_h", 32'(vif_a.h), 300);
    check("mid_a_v", 32'(vif_a.v), 21);
    rst = 1'b0;
    #1;
    check_reset_state("async_rst");

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_origin("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
